// File: rtl/result_shift_pkg.sv
// Shared types and constants for the compressor result serializer.
package result_shift_pkg;

    localparam int DEFAULT_WIDTH = 29;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/result_shift_out.sv
// Latches a parallel compressor result and streams it out LSB first over a
// valid/ready serial link, followed by one even-parity bit marked as last.
module result_shift_out
    import result_shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [WIDTH-1:0] dst,
    input  logic             sout_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CNT_W-1:0] cnt;
    logic             par_acc;
    logic             xfer;

    assign xfer      = sout_valid && sout_ready;
    assign shreg_nxt = shreg >> 1;

    // Outputs are registered one bit ahead: on each transfer the next bit to
    // present is taken from the post-shift register, so sout never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            par_acc    <= 1'b0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        state      <= SHIFT;
                        shreg      <= dst;
                        cnt        <= '0;
                        par_acc    <= 1'b0;
                        sout       <= dst[0];
                        sout_valid <= 1'b1;
                        sout_last  <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (capture) overrun <= 1'b1;
                    if (xfer) begin
                        shreg   <= shreg_nxt;
                        cnt     <= cnt + 1'b1;
                        par_acc <= par_acc ^ shreg[0];
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            // Parity covers every latched bit, including the one leaving now.
                            state     <= PARITY;
                            sout      <= par_acc ^ shreg[0];
                            sout_last <= 1'b1;
                        end else begin
                            sout <= shreg_nxt[0];
                        end
                    end
                end
                PARITY: begin
                    if (capture) overrun <= 1'b1;
                    if (xfer) begin
                        state      <= IDLE;
                        cnt        <= cnt + 1'b1;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        sout_last  <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_shift_out.sv
// Randomized and directed bench for result_shift_out with a queue scoreboard.
module tb_result_shift_out;
    import result_shift_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         capture = 1'b0;
    logic [W-1:0] dst = '0;
    logic         sout_ready = 1'b0;
    logic         sout, sout_valid, sout_last, busy, done, overrun;

    result_shift_out #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .capture(capture), .dst(dst),
        .sout_ready(sout_ready), .sout(sout), .sout_valid(sout_valid),
        .sout_last(sout_last), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } item_t;

    item_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    mon_en = 1'b0;

    // Behavioural model: a frame is a list of WIDTH+1 expected symbols; the
    // link is busy while any of them remain untransferred.
    int m_left = 0;
    bit m_active = 1'b0, m_done = 1'b0, m_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit was_active;
        bit p;
        if (rst) begin
            m_active = 1'b0; m_left = 0; m_done = 1'b0; m_ovr = 1'b0;
            exp_q.delete();
        end else begin
            was_active = m_active;
            m_done = 1'b0;
            if (m_active && sout_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (capture) begin
                if (was_active) m_ovr = 1'b1;
                else begin
                    p = 1'b0;
                    for (int i = 0; i < W; i++) begin
                        exp_q.push_back('{b: dst[i], last: 1'b0});
                        p = p ^ dst[i];
                    end
                    exp_q.push_back('{b: p, last: 1'b1});
                    m_active = 1'b1;
                    m_left = W + 1;
                end
            end
        end
    end

    logic prev_stall = 1'b0, prev_sout = 1'b0, prev_last = 1'b0;
    always @(negedge clk) begin
        item_t it;
        if (mon_en) begin
            check("sout_valid", sout_valid, m_active);
            check("busy", busy, m_active);
            check("done", done, m_done);
            check("overrun", overrun, m_ovr);
            if (!sout_valid) begin
                check("idle_sout", sout, 1'b0);
                check("idle_last", sout_last, 1'b0);
            end
            if (prev_stall && !rst) begin
                check("stall_sout", sout, prev_sout);
                check("stall_last", sout_last, prev_last);
            end
            if (sout_valid && sout_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", 1'b1, 1'b0);
                end else begin
                    it = exp_q.pop_front();
                    check("sout_bit", sout, it.b);
                    check("sout_last", sout_last, it.last);
                end
            end
            prev_stall = sout_valid && !sout_ready && !rst;
            prev_sout  = sout;
            prev_last  = sout_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; capture = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic do_capture(input logic [W-1:0] d);
        dst = d; capture = 1'b1;
        step();
        capture = 1'b0;
    endtask

    initial begin
        step();
        mon_en = 1'b1;
        do_reset(2);

        // Single set bit, LSB first, ready held high.
        sout_ready = 1'b1;
        do_capture(29'h0000001);
        repeat (33) step();

        // All ones.
        do_capture(29'h1FFFFFFF);
        repeat (33) step();

        // Alternating pattern with ready toggling every cycle.
        sout_ready = 1'b1;
        do_capture(29'h0AAAAAAA);
        for (int c = 1; c < 70; c++) begin
            sout_ready = (c % 2 == 0);
            step();
        end
        sout_ready = 1'b1;
        repeat (3) step();

        // Second capture mid-frame is dropped and flags overrun.
        do_capture(29'h0000001);
        repeat (4) step();
        do_capture(29'h1234567);
        repeat (40) step();
        do_reset(1);
        step();

        // Reset mid-frame, then a fresh frame.
        do_capture(29'h1FFFFFFF);
        repeat (9) step();
        do_reset(1);
        step();
        do_capture(29'h0000005);
        repeat (33) step();

        // dst changes every cycle after the capture edge.
        do_capture(29'h0000003);
        for (int c = 0; c < 33; c++) begin
            dst = W'($urandom);
            step();
        end

        // Random traffic with occasional resets and dropped captures.
        for (int c = 0; c < 1500; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            capture    = ($urandom_range(0, 9) == 0);
            sout_ready = ($urandom_range(0, 3) != 0);
            dst        = W'($urandom);
            step();
        end
        rst = 1'b0; capture = 1'b0; sout_ready = 1'b1;
        repeat (70) step();

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
